// File: rtl/cacc_slcg_pkg.sv
// Shared definitions for the CACC second-level clock-gating controller.
// Holds the per-source FSM state encoding and the default timing parameters.
package cacc_slcg_pkg;

  typedef enum logic [1:0] {
    S_GATED  = 2'd0,
    S_WAKE   = 2'd1,
    S_ACTIVE = 2'd2,
    S_HYST   = 2'd3
  } slcg_state_t;

  localparam int WAKE_LAT_DEF = 2;  // cycles from enable to ack (1..15)
  localparam int HYST_W_DEF   = 8;  // idle-hysteresis counter width

endpackage

// File: rtl/cacc_slcg_chan.sv
// One clock-gating channel: GATED -> WAKE -> ACTIVE -> HYST FSM with its wake
// and idle-hysteresis counters.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   req             level activity request, held while work is pending
//   cfg_idle_hyst   idle cycles tolerated before re-gating (sampled on ACTIVE exit)
//   en              clock enable (decoded from state flops)
//   ack             clock running and stable (decoded from state flops)
module cacc_slcg_chan
  import cacc_slcg_pkg::*;
#(
  parameter int WAKE_LAT = WAKE_LAT_DEF,
  parameter int HYST_W   = HYST_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [HYST_W-1:0] cfg_idle_hyst,
  output logic              en,
  output logic              ack
);

  localparam logic [3:0]        WAKE_LOAD = 4'(WAKE_LAT - 1);
  localparam logic [HYST_W-1:0] HYST_ONE  = {{(HYST_W-1){1'b0}}, 1'b1};

  slcg_state_t       state, state_nx;
  logic [3:0]        wake_cnt, wake_cnt_nx;
  logic [HYST_W-1:0] hyst_cnt, hyst_cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_GATED;
      wake_cnt <= '0;
      hyst_cnt <= '0;
    end else begin
      state    <= state_nx;
      wake_cnt <= wake_cnt_nx;
      hyst_cnt <= hyst_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wake_cnt_nx = wake_cnt;
    hyst_cnt_nx = hyst_cnt;
    case (state)
      S_GATED: if (req) begin
        state_nx    = S_WAKE;
        wake_cnt_nx = WAKE_LOAD;
      end
      // Wake always runs to completion so the gater sees a full settle time,
      // even if the request has already been withdrawn.
      S_WAKE: begin
        if (wake_cnt == 4'd0) state_nx    = S_ACTIVE;
        else                  wake_cnt_nx = wake_cnt - 4'd1;
      end
      S_ACTIVE: if (!req) begin
        if (cfg_idle_hyst == '0) begin
          state_nx = S_GATED;
        end else begin
          state_nx    = S_HYST;
          hyst_cnt_nx = cfg_idle_hyst;
        end
      end
      // Clock is still running here, so a returning request is acked with no
      // wake latency. The <= guards against ever wrapping below zero.
      S_HYST: begin
        if (req) begin
          state_nx = S_ACTIVE;
        end else if (hyst_cnt <= HYST_ONE) begin
          state_nx    = S_GATED;
          hyst_cnt_nx = '0;
        end else begin
          hyst_cnt_nx = hyst_cnt - 1'b1;
        end
      end
      default: state_nx = S_GATED;
    endcase
  end

  assign en  = (state != S_GATED);
  assign ack = (state == S_ACTIVE);

endmodule

// File: rtl/cacc_slcg_ctrl.sv
// CACC second-level clock-gating controller: two independent gating channels
// (assembly = 0, delivery = 1), a registered global override, and an optional
// all-gated performance counter.
// Optional feature macro: CACC_SLCG_PERF_EN (enables the gated_cycles counter;
// otherwise gated_cycles is tied to 0).
// Ports:
//   nvdla_core_clk, nvdla_core_rstn         clock, async active-low reset
//   req_0, req_1                            per-domain activity requests
//   cfg_idle_hyst                           idle hysteresis length
//   tmc2slcg_disable_clock_gating,
//   global_clk_ovr_on_sync, dla_clk_ovr_on_sync   gating overrides (synchronous)
//   slcg_en_src_0, slcg_en_src_1            clock enables to the gaters
//   ack_0, ack_1                            domain clock running and stable
//   gated_cycles                            cycles with both enables low
module cacc_slcg_ctrl
  import cacc_slcg_pkg::*;
#(
  parameter int WAKE_LAT = WAKE_LAT_DEF,
  parameter int HYST_W   = HYST_W_DEF
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              req_0,
  input  logic              req_1,
  input  logic [HYST_W-1:0] cfg_idle_hyst,
  input  logic              tmc2slcg_disable_clock_gating,
  input  logic              global_clk_ovr_on_sync,
  input  logic              dla_clk_ovr_on_sync,
  output logic              slcg_en_src_0,
  output logic              slcg_en_src_1,
  output logic              ack_0,
  output logic              ack_1,
  output logic [31:0]       gated_cycles
);

  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0] req_v, en_v, ack_v;
  logic               force_q;

  assign req_v = {req_1, req_0};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_chan
    cacc_slcg_chan #(.WAKE_LAT(WAKE_LAT), .HYST_W(HYST_W)) u_chan (
      .clk           (nvdla_core_clk),
      .rst_n         (nvdla_core_rstn),
      .req           (req_v[i]),
      .cfg_idle_hyst (cfg_idle_hyst),
      .en            (en_v[i]),
      .ack           (ack_v[i])
    );
  end

  // Override only holds the clocks on; it never acks, so requesters still
  // wait for their own channel to wake.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) force_q <= 1'b0;
    else force_q <= tmc2slcg_disable_clock_gating | global_clk_ovr_on_sync | dla_clk_ovr_on_sync;
  end

  assign slcg_en_src_0 = en_v[0] | force_q;
  assign slcg_en_src_1 = en_v[1] | force_q;
  assign ack_0         = ack_v[0];
  assign ack_1         = ack_v[1];

`ifdef CACC_SLCG_PERF_EN
  logic [31:0] gated_q;
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) gated_q <= '0;
    else if (!slcg_en_src_0 && !slcg_en_src_1 && (gated_q != 32'hFFFF_FFFF))
      gated_q <= gated_q + 32'd1;
  end
  assign gated_cycles = gated_q;
`else
  assign gated_cycles = '0;
`endif

endmodule

// File: doc/cacc_slcg_ctrl.md
CACC_SLCG_CTRL -- requirements
Module: cacc_slcg_ctrl

Interface
REQ-001 Parameter WAKE_LAT, default 2, SHALL set cycles from enable assertion to ack (legal range 1..15).
REQ-002 Parameter HYST_W, default 8, SHALL set the width of the idle-hysteresis counter and of cfg_idle_hyst.
REQ-003 nvdla_core_clk  in  1  sole clock; rising edge.
REQ-004 nvdla_core_rstn  in  1  reset, asynchronous, active-low.
REQ-005 req_0 / req_1  in  1 each  activity request from the assembly (0) and delivery (1) sides; level, held while work is pending.
REQ-006 cfg_idle_hyst  in  HYST_W  idle cycles before re-gating; static while any req is high.
REQ-007 tmc2slcg_disable_clock_gating, global_clk_ovr_on_sync, dla_clk_ovr_on_sync  in  1 each  gating overrides; already synchronous to nvdla_core_clk.
REQ-008 slcg_en_src_0 / slcg_en_src_1  out  1 each  clock-enable to the gater of each domain.
REQ-009 ack_0 / ack_1  out  1 each  domain clock is running and stable; requester may issue work.
REQ-010 gated_cycles  out  32  performance count (see Configuration).

Function
REQ-011 Each source SHALL have an independent FSM: GATED, WAKE, ACTIVE, HYST.
REQ-012 GATED: en=0, ack=0; req=1 -> WAKE, wake counter loaded with WAKE_LAT-1.
REQ-013 WAKE: en=1, ack=0; counter decrements each cycle; at 0 -> ACTIVE; req dropping in WAKE does not abort WAKE.
REQ-014 ACTIVE: en=1, ack=1; req=0 -> HYST with counter loaded from cfg_idle_hyst; if cfg_idle_hyst==0 -> GATED directly.
REQ-015 HYST: en=1, ack=0; req=1 -> ACTIVE next cycle (no wake latency); else counter decrements; at 1 with req=0 -> GATED.
REQ-016 Latency: en rises 1 cycle after req is first sampled high; ack rises WAKE_LAT cycles after en.
REQ-017 Outputs en/ack SHALL be registered (state-decoded from flops), with no combinational path from req.
REQ-018 Override: force = OR of the three override inputs, registered once; slcg_en_src_n = fsm_en | force_q; ack and FSM are unaffected by force.
REQ-019 Simultaneous req_0 and req_1 SHALL be serviced in parallel; no arbitration or ordering between sources.
REQ-020 Counters SHALL NOT wrap; the wake and hysteresis counters stop at 0.

Reset
REQ-021 Reset asserted: both FSMs -> GATED, counters 0, force_q 0, gated_cycles 0; all outputs 0.
REQ-022 Reset asserted mid-WAKE/ACTIVE/HYST SHALL drop en and ack immediately (asynchronously); after release, a held req restarts from GATED per REQ-012.

Configuration
REQ-023 With CACC_SLCG_PERF_EN defined: gated_cycles increments by 1 each cycle in which slcg_en_src_0 and slcg_en_src_1 are both 0, and saturates at 0xFFFFFFFF.
REQ-024 Without CACC_SLCG_PERF_EN: gated_cycles is tied to 0 and no counter flops exist.

Structure
REQ-025 The FSM state enum and the WAKE_LAT/HYST_W defaults SHALL live in the shared package cacc_slcg_pkg.
REQ-026 The per-source FSM plus counters SHALL be one sub-module, cacc_slcg_chan, instantiated twice; the top holds the override register and the perf counter.

Verification
REQ-027 req_0 rises at cycle 10, WAKE_LAT=2 -> slcg_en_src_0=1 at cycle 11, ack_0=1 at cycle 13; src_1 stays 0.
REQ-028 req_0 falls at cycle 50, cfg_idle_hyst=4 -> ack_0=0 at cycle 51; en_0 stays 1 through cycle 54; en_0=0 at cycle 55.
REQ-029 Set cfg_idle_hyst=4; in HYST, req_0 reasserts 2 cycles after dropping -> ack_0=1 the next cycle, en_0 never drops.
REQ-030 cfg_idle_hyst=0, req_1 pulse of 5 cycles -> GATED 1 cycle after req_1 falls (after WAKE completes).
REQ-031 tmc2slcg_disable_clock_gating=1 with no req -> both en=1 one cycle later, ack=0; deassert -> en=0 one cycle later.
REQ-032 Reset asserted while ACTIVE with req held -> en/ack 0 immediately; after release, en at +1 and ack at +1+WAKE_LAT. With CACC_SLCG_PERF_EN: 100 idle cycles after reset -> gated_cycles=100.
